floo_axis_beat_splitter: RTL and testbench
==========================================

// Module: floo_axis_beat_splitter
// PURPOSE
//  Tx-side stage directly downstream of floo_axis_noc_bridge.axis_out_req_o.
//  Captures one wide AXIS beat (packed flit payload) and emits it as
//  NumBeats narrow beats, LSB chunk first, toward the serial link data link layer.
//  The last narrow beat carries out_tlast_o.
//  One-entry holding register plus beat counter: fully registered, no combinational in->out path.
// PARAMETERS
//  InWidth   128  width of wide input tdata (bits, multiple of 8)
//  OutWidth  32   width of narrow output tdata (bits, multiple of 8, <= InWidth)
//  NumBeats  derived = ceil(InWidth/OutWidth); CntWidth = max(1, $clog2(NumBeats))
// PORTS
//  clk_i        in   1         clock
//  rst_ni       in   1         asynchronous reset, active-low
//  in_tvalid_i  in   1         wide beat valid (from bridge)
//  in_tready_o  out  1         wide beat ready
//  in_tdata_i   in   InWidth   wide beat payload
//  out_tvalid_o out  1         narrow beat valid
//  out_tready_i in   1         narrow beat ready (from link)
//  out_tdata_o  out  OutWidth  narrow beat payload
//  out_tlast_o  out  1         high on final narrow beat of a wide beat
//  busy_o       out  1         holding register occupied
// BEHAVIOUR
//  Reset: state IDLE, cnt=0, hold_q='0; out_tvalid_o=0, out_tlast_o=0, out_tdata_o='0, busy_o=0, in_tready_o=1.
//  FSM IDLE: in_tready_o=1; on in_tvalid_i&in_tready_o -> hold_q<=in_tdata_i zero-extended to NumBeats*OutWidth, cnt<=0, go SEND.
//  FSM SEND: out_tvalid_o=1, out_tdata_o=hold_q[cnt*OutWidth +: OutWidth], out_tlast_o=(cnt==NumBeats-1).
//   - out_tvalid_o&out_tready_i & !last: cnt<=cnt+1, stay SEND.
//   - out_tvalid_o&out_tready_i & last: cnt<=0, go IDLE (base behaviour).
//   - !out_tready_i: hold all outputs stable (AXIS rule: valid never drops, data never changes).
//  in_tready_o=0 throughout SEND in base build.
//  Latency: first narrow beat valid the cycle after wide-beat acceptance.
//  Throughput base: NumBeats+1 cycles per wide beat under no backpressure.
//  Non-divisible widths: top chunk zero-padded above bit InWidth-1.
//  NumBeats==1: single beat, out_tlast_o=1 every valid beat.
//  cnt never exceeds NumBeats-1; no wrap beyond.
//  Reset asserted mid-SEND: held beat discarded, outputs return to reset values immediately (async).
//  busy_o = (state==SEND).
// CONFIGURATION
//  FLOO_AXIS_SPLIT_PREFETCH_EN defined:
//   in_tready_o = IDLE | (SEND & last & out_tready_i).
//   Acceptance on the final narrow handshake reloads hold_q, cnt<=0, stays SEND.
//   Back-to-back throughput becomes exactly NumBeats cycles per wide beat (no bubble).
//   in_tready_o then depends combinationally on out_tready_i.
//  Not defined: base behaviour above; in_tready_o purely registered-state driven.
// TESTING
//  T1 InWidth=128,OutWidth=32, in 0x44444444_33333333_22222222_11111111, ready=1 -> out 0x11111111,0x22222222,0x33333333,0x44444444 on consecutive cycles; tlast only on 4th.
//  T2 same beat, out_tready_i low 3 cycles on beat 2 -> out_tdata_o holds 0x22222222, valid stays 1, in_tready_o=0, no beat lost or duplicated.
//  T3 InWidth=72,OutWidth=32, in 0xAB_CCCCCCCC_DDDDDDDD -> 0xDDDDDDDD,0xCCCCCCCC,0x000000AB, tlast on 3rd.
//  T4 Two wide beats presented continuously, ready=1: base -> 9 cycles, 1-cycle bubble after 4th narrow beat; with FLOO_AXIS_SPLIT_PREFETCH_EN -> 8 cycles, no bubble.
//  T5 rst_ni low after 2nd narrow beat -> out_tvalid_o=0, busy_o=0 immediately; after release next input starts at chunk 0.
//  T6 Random valid/ready, 1000 wide beats, scoreboard reassembles narrow beats on tlast -> every wide beat matches in order; AXIS stability assertions hold.

Source files
------------

// File: rtl/floo_axis_beat_splitter_if.sv
// floo_axis_beat_splitter_if: wide-in / narrow-out AXIS stream pair around the beat splitter.
interface floo_axis_beat_splitter_if #(
  parameter int unsigned InWidth  = 128,
  parameter int unsigned OutWidth = 32
);
  logic                in_tvalid_i;
  logic                in_tready_o;
  logic [InWidth-1:0]  in_tdata_i;
  logic                out_tvalid_o;
  logic                out_tready_i;
  logic [OutWidth-1:0] out_tdata_o;
  logic                out_tlast_o;
  modport slave (
    input  in_tvalid_i, in_tdata_i, out_tready_i,
    output in_tready_o, out_tvalid_o, out_tdata_o, out_tlast_o
  );
  modport master (
    output in_tvalid_i, in_tdata_i, out_tready_i,
    input  in_tready_o, out_tvalid_o, out_tdata_o, out_tlast_o
  );
endinterface

// File: rtl/floo_axis_beat_splitter.sv
// floo_axis_beat_splitter: splits one wide AXIS beat into NumBeats narrow beats, LSB chunk first (FLOO_AXIS_SPLIT_PREFETCH_EN reloads on the last narrow handshake).
module floo_axis_beat_splitter #(
  parameter int unsigned InWidth  = 128,
  parameter int unsigned OutWidth = 32
) (
  input  logic clk_i,
  input  logic rst_ni,
  floo_axis_beat_splitter_if.slave axis,
  output logic busy_o
);
  localparam int unsigned NumBeats = (InWidth + OutWidth - 1) / OutWidth;
  localparam int unsigned CntWidth = NumBeats > 1 ? $clog2(NumBeats) : 1;
  localparam int unsigned PadWidth = NumBeats * OutWidth;
  typedef enum logic {IDLE, SEND} state_e;
  state_e              state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic [PadWidth-1:0] hold_q, hold_d;
  logic                send, last, fire, load;
  // Handshake decode, next state and outputs; outputs come only from registered state
  always_comb begin
    send = state_q == SEND;
    last = cnt_q == CntWidth'(NumBeats - 1);
    fire = send && axis.out_tready_i;
`ifdef FLOO_AXIS_SPLIT_PREFETCH_EN
    axis.in_tready_o = !send || (last && axis.out_tready_i);
`else
    axis.in_tready_o = !send;
`endif
    load = axis.in_tvalid_i && axis.in_tready_o;
    state_d = load ? SEND : (fire && last) ? IDLE : state_q;
    cnt_d = (load || (fire && last)) ? '0 : fire ? cnt_q + 1'b1 : cnt_q;
    hold_d = load ? PadWidth'(axis.in_tdata_i) : hold_q;
    axis.out_tvalid_o = send;
    axis.out_tlast_o = send && last;
    axis.out_tdata_o = send ? hold_q[cnt_q*OutWidth +: OutWidth] : '0;
    busy_o = send;
  end
  // State, beat counter and holding register; reset drops any held beat
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q <= '0;
      hold_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      hold_q <= hold_d;
    end
  end
endmodule

// File: tb/tb_floo_axis_beat_splitter.sv
// tb_floo_axis_beat_splitter: directed and random checks of the wide-to-narrow beat splitter.
module tb_floo_axis_beat_splitter;
  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic busy_a, busy_b;
  int errors = 0;
  int checks = 0;
  floo_axis_beat_splitter_if #(.InWidth(128), .OutWidth(32)) a ();
  floo_axis_beat_splitter_if #(.InWidth(72), .OutWidth(32)) b ();
  floo_axis_beat_splitter #(.InWidth(128), .OutWidth(32)) dut_a (
    .clk_i(clk_i), .rst_ni(rst_ni), .axis(a.slave), .busy_o(busy_a)
  );
  floo_axis_beat_splitter #(.InWidth(72), .OutWidth(32)) dut_b (
    .clk_i(clk_i), .rst_ni(rst_ni), .axis(b.slave), .busy_o(busy_b)
  );
  always #5 clk_i = ~clk_i;

  task automatic test_reset;
    a.in_tvalid_i = 0; a.in_tdata_i = '0; a.out_tready_i = 0;
    b.in_tvalid_i = 0; b.in_tdata_i = '0; b.out_tready_i = 0;
    rst_ni = 0;
    repeat (2) @(negedge clk_i);
    checks++; if (a.out_tvalid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", a.out_tvalid_o); end
    checks++; if (a.out_tlast_o !== 1'b0) begin errors++; $display("FAIL reset_tlast got %b exp 0", a.out_tlast_o); end
    checks++; if (a.out_tdata_o !== 32'h0) begin errors++; $display("FAIL reset_tdata got %h exp 0", a.out_tdata_o); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy_a); end
    checks++; if (a.in_tready_o !== 1'b1) begin errors++; $display("FAIL reset_in_tready got %b exp 1", a.in_tready_o); end
    rst_ni = 1;
    @(negedge clk_i);
  endtask

  task automatic test_basic;
    logic [31:0] exp [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    a.in_tdata_i = 128'h44444444_33333333_22222222_11111111;
    a.in_tvalid_i = 1; a.out_tready_i = 1;
    checks++; if (a.in_tready_o !== 1'b1) begin errors++; $display("FAIL t1_in_tready got %b exp 1", a.in_tready_o); end
    @(negedge clk_i);
    a.in_tvalid_i = 0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (a.out_tvalid_o !== 1'b1) begin errors++; $display("FAIL t1_valid[%0d] got %b exp 1", i, a.out_tvalid_o); end
      checks++; if (a.out_tdata_o !== exp[i]) begin errors++; $display("FAIL t1_data[%0d] got %h exp %h", i, a.out_tdata_o, exp[i]); end
      checks++; if (a.out_tlast_o !== (i == 3)) begin errors++; $display("FAIL t1_tlast[%0d] got %b exp %b", i, a.out_tlast_o, i == 3); end
      checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL t1_busy[%0d] got %b exp 1", i, busy_a); end
      @(negedge clk_i);
    end
    checks++; if (a.out_tvalid_o !== 1'b0) begin errors++; $display("FAIL t1_idle_valid got %b exp 0", a.out_tvalid_o); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL t1_idle_busy got %b exp 0", busy_a); end
  endtask

  task automatic test_backpressure;
    logic [31:0] exp [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    a.in_tdata_i = 128'h44444444_33333333_22222222_11111111;
    a.in_tvalid_i = 1; a.out_tready_i = 1;
    @(negedge clk_i);
    a.in_tvalid_i = 0;
    checks++; if (a.out_tdata_o !== exp[0]) begin errors++; $display("FAIL t2_beat0 got %h exp %h", a.out_tdata_o, exp[0]); end
    @(negedge clk_i);
    a.out_tready_i = 0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (a.out_tvalid_o !== 1'b1) begin errors++; $display("FAIL t2_stall_valid[%0d] got %b exp 1", i, a.out_tvalid_o); end
      checks++; if (a.out_tdata_o !== exp[1]) begin errors++; $display("FAIL t2_stall_data[%0d] got %h exp %h", i, a.out_tdata_o, exp[1]); end
      checks++; if (a.in_tready_o !== 1'b0) begin errors++; $display("FAIL t2_stall_in_tready[%0d] got %b exp 0", i, a.in_tready_o); end
      @(negedge clk_i);
    end
    a.out_tready_i = 1;
    for (int i = 1; i < 4; i++) begin
      checks++; if (a.out_tdata_o !== exp[i] || a.out_tlast_o !== (i == 3)) begin errors++; $display("FAIL t2_data[%0d] got %h/%b exp %h/%b", i, a.out_tdata_o, a.out_tlast_o, exp[i], i == 3); end
      @(negedge clk_i);
    end
    checks++; if (a.out_tvalid_o !== 1'b0) begin errors++; $display("FAIL t2_idle_valid got %b exp 0", a.out_tvalid_o); end
  endtask

  task automatic test_odd_width;
    logic [31:0] exp [3] = '{32'hDDDDDDDD, 32'hCCCCCCCC, 32'h000000AB};
    b.in_tdata_i = 72'hAB_CCCCCCCC_DDDDDDDD;
    b.in_tvalid_i = 1; b.out_tready_i = 1;
    @(negedge clk_i);
    b.in_tvalid_i = 0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (b.out_tvalid_o !== 1'b1 || b.out_tdata_o !== exp[i]) begin errors++; $display("FAIL t3_data[%0d] got %b/%h exp 1/%h", i, b.out_tvalid_o, b.out_tdata_o, exp[i]); end
      checks++; if (b.out_tlast_o !== (i == 2)) begin errors++; $display("FAIL t3_tlast[%0d] got %b exp %b", i, b.out_tlast_o, i == 2); end
      @(negedge clk_i);
    end
    checks++; if (b.out_tvalid_o !== 1'b0) begin errors++; $display("FAIL t3_idle_valid got %b exp 0", b.out_tvalid_o); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp [8] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444,
                             32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888};
    int cyc = 0, acc = 0, nb = 0, first = -1, lastc = -1, bubbles = 0;
`ifdef FLOO_AXIS_SPLIT_PREFETCH_EN
    int exp_span = 8, exp_bubbles = 0;
`else
    int exp_span = 9, exp_bubbles = 1;
`endif
    a.in_tdata_i = 128'h44444444_33333333_22222222_11111111;
    a.in_tvalid_i = 1; a.out_tready_i = 1;
    while (nb < 8 && cyc < 40) begin
      if (a.out_tvalid_o) begin
        checks++; if (a.out_tdata_o !== exp[nb] || a.out_tlast_o !== (nb % 4 == 3)) begin errors++; $display("FAIL t4_data[%0d] got %h/%b exp %h/%b", nb, a.out_tdata_o, a.out_tlast_o, exp[nb], nb % 4 == 3); end
        nb++; lastc = cyc;
      end else if (nb > 0) bubbles++;
      if (a.in_tvalid_i && a.in_tready_o) begin
        if (first < 0) first = cyc;
        acc++;
      end
      @(negedge clk_i);
      cyc++;
      if (acc == 1) a.in_tdata_i = 128'h88888888_77777777_66666666_55555555;
      if (acc == 2) a.in_tvalid_i = 0;
    end
    checks++; if (nb != 8) begin errors++; $display("FAIL t4_beats got %0d exp 8", nb); end
    checks++; if (lastc - first != exp_span) begin errors++; $display("FAIL t4_span got %0d exp %0d", lastc - first, exp_span); end
    checks++; if (bubbles != exp_bubbles) begin errors++; $display("FAIL t4_bubbles got %0d exp %0d", bubbles, exp_bubbles); end
    a.in_tvalid_i = 0;
    @(negedge clk_i);
  endtask

  task automatic test_reset_mid;
    logic [31:0] exp [4] = '{32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888};
    a.in_tdata_i = 128'h44444444_33333333_22222222_11111111;
    a.in_tvalid_i = 1; a.out_tready_i = 1;
    @(negedge clk_i);
    a.in_tvalid_i = 0;
    repeat (2) @(negedge clk_i);
    checks++; if (busy_a !== 1'b1 || a.out_tdata_o !== 32'h33333333) begin errors++; $display("FAIL t5_pre got %b/%h exp 1/33333333", busy_a, a.out_tdata_o); end
    rst_ni = 0;
    #1;
    checks++; if (a.out_tvalid_o !== 1'b0) begin errors++; $display("FAIL t5_valid got %b exp 0", a.out_tvalid_o); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL t5_busy got %b exp 0", busy_a); end
    checks++; if (a.in_tready_o !== 1'b1 || a.out_tdata_o !== 32'h0) begin errors++; $display("FAIL t5_outputs got %b/%h exp 1/0", a.in_tready_o, a.out_tdata_o); end
    @(negedge clk_i);
    rst_ni = 1;
    @(negedge clk_i);
    a.in_tdata_i = 128'h88888888_77777777_66666666_55555555;
    a.in_tvalid_i = 1;
    @(negedge clk_i);
    a.in_tvalid_i = 0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (a.out_tvalid_o !== 1'b1 || a.out_tdata_o !== exp[i]) begin errors++; $display("FAIL t5_after[%0d] got %b/%h exp 1/%h", i, a.out_tvalid_o, a.out_tdata_o, exp[i]); end
      @(negedge clk_i);
    end
  endtask

  task automatic test_random;
    logic [127:0] sent [$];
    logic [127:0] asm = '0, w;
    logic [31:0] pdata = '0;
    logic stall = 0, took;
    int done = 0, nchunk = 0, cyc = 0;
    a.in_tvalid_i = 0;
    while (done < 1000 && cyc < 60000) begin
      a.out_tready_i = ($urandom_range(0, 3) != 0);
      if (!a.in_tvalid_i && $urandom_range(0, 1) == 1) begin
        a.in_tdata_i = {$urandom, $urandom, $urandom, $urandom};
        a.in_tvalid_i = 1;
      end
      #1;
      if (stall) begin
        checks++; if (a.out_tvalid_o !== 1'b1 || a.out_tdata_o !== pdata) begin errors++; $display("FAIL t6_stable got %b/%h exp 1/%h", a.out_tvalid_o, a.out_tdata_o, pdata); end
      end
      stall = a.out_tvalid_o && !a.out_tready_i;
      pdata = a.out_tdata_o;
      if (a.out_tvalid_o && a.out_tready_i) begin
        if (nchunk < 4) asm[nchunk*32 +: 32] = a.out_tdata_o;
        nchunk++;
        if (a.out_tlast_o) begin
          w = sent.size() != 0 ? sent.pop_front() : 'x;
          checks++; if (nchunk != 4 || asm !== w) begin errors++; $display("FAIL t6_beat[%0d] got %h (%0d chunks) exp %h", done, asm, nchunk, w); end
          nchunk = 0; done++;
        end
      end
      took = a.in_tvalid_i && a.in_tready_o;
      if (took) sent.push_back(a.in_tdata_i);
      @(negedge clk_i);
      if (took) a.in_tvalid_i = 0;
      cyc++;
    end
    checks++; if (done != 1000) begin errors++; $display("FAIL t6_count got %0d exp 1000", done); end
    a.in_tvalid_i = 0; a.out_tready_i = 1;
    repeat (6) @(negedge clk_i);
  endtask

  initial begin
    @(negedge clk_i);
    test_reset;
    test_basic;
    test_backpressure;
    test_odd_width;
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
